ysyx_23060332_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core. It owns the PC and issues word fetches over a valid/ready request and response memory port. It presents each fetched instruction plus its address to the decode stage with a valid/ready handshake. It accepts PC redirects from the execute stage (jal/jalr) and discards any stale in-flight fetch.

---
 rtl/ysyx_23060332_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// rtl/ysyx_23060332_ifu.sv - instruction fetch unit: PC owner, single-outstanding word fetch, decode handoff
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        misalign_q, misalign_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic [31:0] tgt;

    assign tgt        = {redirect_pc[31:2], 2'b00};
    assign misalign_d = redirect_en && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        case (state_q)
            S_REQ: begin
                if (redirect_en) begin
                    pc_d = tgt;
                end
                // A redirect racing an accepted request leaves a stale response to swallow.
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_en;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (!drop_q && !redirect_en) begin
                        inst_d      = mem_resp_data;
                        inst_addr_d = pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_en) begin
                            pc_d = tgt;
                        end
                    end
                end else if (redirect_en) begin
                    pc_d   = tgt;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            misalign_q  <= 1'b0;
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            misalign_q  <= misalign_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    assign mem_req_valid = !rst && (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign inst_valid    = !rst && (state_q == S_HOLD);
    assign inst_o        = rst ? NOP_INST : inst_q;
    assign inst_addr_o   = inst_addr_q;
    assign pc_o          = pc_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// tb/tb_ysyx_23060332_ifu.sv - randomized scoreboard bench for the instruction fetch unit
module tb_ysyx_23060332_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic [31:0] inst_o, inst_addr_o, redirect_pc, pc_o;
    logic        inst_valid, inst_ready, redirect_en, misalign_o;

    logic        w_rst, w_req_valid, w_req_ready, w_resp_valid;
    logic [31:0] w_req_addr, w_resp_data, w_inst, w_inst_addr, w_pc;
    logic        w_inst_valid, w_inst_ready, w_misalign;

    always #5 clk = ~clk;

    ysyx_23060332_ifu u_dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc_o(pc_o), .misalign_o(misalign_o)
    );

    ysyx_23060332_ifu #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(w_rst),
        .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
        .mem_resp_valid(w_resp_valid), .mem_resp_data(w_resp_data),
        .inst_o(w_inst), .inst_addr_o(w_inst_addr), .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .redirect_en(1'b0), .redirect_pc(32'h0), .pc_o(w_pc), .misalign_o(w_misalign)
    );

    int tests = 0;
    int fails = 0;
    int deliveries = 0;
    int p_ready = 70, p_iready = 60, p_redir = 5;

    logic [31:0] exp_q[$];
    logic        exp_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Driver, memory model and reference model of which address decode sees next.
    initial begin : driver
        logic        s_rst, s_req_v, s_req_r, s_iv, s_ir, s_re;
        logic [31:0] s_addr, s_ia, s_rpc, pend_addr;
        logic        outstanding;
        int          cnt;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        inst_ready = 0; redirect_en = 0; redirect_pc = 0;
        outstanding = 0; cnt = 0; pend_addr = 0;
        forever begin
            @(negedge clk);
            s_rst = rst; s_req_v = mem_req_valid; s_req_r = mem_req_ready; s_addr = mem_req_addr;
            s_iv = inst_valid; s_ir = inst_ready; s_ia = inst_addr_o;
            s_re = redirect_en; s_rpc = redirect_pc;
            @(posedge clk);
            #1;
            mem_resp_valid = 0;
            if (s_rst) begin
                exp_q.delete();
                exp_q.push_back(32'h8000_0000);
                exp_mis = 0;
                outstanding = 0;
            end else begin
                exp_mis = s_re && (s_rpc[1:0] != 2'b00);
                if (s_re) begin
                    exp_q.delete();
                    exp_q.push_back({s_rpc[31:2], 2'b00});
                end else if (s_iv && s_ir) begin
                    exp_q.push_back(s_ia + 32'd4);
                end
                if (s_req_v && s_req_r) begin
                    check("single_outstanding", {31'b0, outstanding}, 32'd0);
                    outstanding = 1;
                    pend_addr = s_addr;
                    cnt = $urandom_range(0, 2);
                end
                if (outstanding) begin
                    if (cnt == 0) begin
                        mem_resp_valid = 1;
                        mem_resp_data = mem_word(pend_addr);
                        outstanding = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
            mem_req_ready = ($urandom_range(0, 99) < p_ready);
            inst_ready    = ($urandom_range(0, 99) < p_iready);
            redirect_en   = ($urandom_range(0, 99) < p_redir);
            redirect_pc   = 32'h8000_0000 + $urandom_range(0, 1023);
        end
    end

    // Monitor: pops the expected address on every new instruction presentation.
    initial begin : monitor
        logic        prev_valid;
        logic [31:0] held_inst, held_addr, e;
        prev_valid = 0; held_inst = 0; held_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
                if (mem_req_valid) check("req_align", {30'b0, mem_req_addr[1:0]}, 32'd0);
                if (inst_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_inst", inst_addr_o, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_addr", inst_addr_o, e);
                        check("inst_data", inst_o, mem_word(e));
                    end
                    held_inst = inst_o;
                    held_addr = inst_addr_o;
                    deliveries++;
                end else if (inst_valid) begin
                    check("hold_inst", inst_o, held_inst);
                    check("hold_addr", inst_addr_o, held_addr);
                    check("hold_no_req", {31'b0, mem_req_valid}, 32'd0);
                end
            end
            prev_valid = inst_valid && !rst;
        end
    end

    initial begin
        rst = 1;
        w_rst = 1; w_req_ready = 0; w_resp_valid = 0; w_resp_data = 0; w_inst_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h8000_0000);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("first_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("first_req_addr", mem_req_addr, 32'h8000_0000);

        repeat (500) @(posedge clk);

        p_iready = 0; p_redir = 0;
        begin : wait_hold
            for (int i = 0; i < 100 && !inst_valid; i++) @(negedge clk);
        end
        check("reach_hold", {31'b0, inst_valid}, 32'd1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); @(negedge clk);
        check("hold_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("hold_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("hold_rst_inst", inst_o, 32'h0000_0013);
        check("hold_rst_pc", pc_o, 32'h8000_0000);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("restart_addr", mem_req_addr, 32'h8000_0000);
        p_iready = 50; p_redir = 25; p_ready = 50;
        repeat (600) @(posedge clk);

        @(posedge clk); #1 w_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrap_req_valid", {31'b0, w_req_valid}, 32'd1);
            check("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        end
        @(posedge clk); #1 w_req_ready = 1;
        @(posedge clk); #1 w_req_ready = 0; w_resp_valid = 1; w_resp_data = 32'h0010_0093;
        @(posedge clk); #1 w_resp_valid = 0;
        @(negedge clk);
        check("wrap_inst_valid", {31'b0, w_inst_valid}, 32'd1);
        check("wrap_inst", w_inst, 32'h0010_0093);
        check("wrap_inst_addr", w_inst_addr, 32'hFFFF_FFFC);
        w_inst_ready = 1;
        @(posedge clk); #1 w_inst_ready = 0;
        @(negedge clk);
        check("wrap_pc", w_pc, 32'h0000_0000);
        check("wrap_next_req", {31'b0, w_req_valid}, 32'd1);

        check("progress", {31'b0, deliveries >= 20}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
